// File: rtl/uart_host_tx_if.sv
// Write-side handshake of the host UART transmitter: a byte producer
// (master) hands bytes to the transmitter FIFO (slave) with valid/ready.
interface uart_host_tx_if;
  logic [7:0] wdata;
  logic       wvalid;
  logic       wready;

  modport master (output wdata, output wvalid, input wready);
  modport slave  (input wdata, input wvalid, output wready);
endinterface

// File: rtl/uart_host_tx.sv
// Host-side 8N1 serial transmitter. Bytes from a valid/ready producer are
// buffered in a small FIFO and shifted out LSB first behind a start bit and
// STOPBITS stop bits. The line output is registered one cycle behind the
// frame state, so a byte accepted into an empty FIFO shows its start bit two
// edges after acceptance. Back-to-back frames have no idle gap.
module uart_host_tx #(
  parameter int DIV      = 1,
  parameter int DEPTH    = 4,
  parameter int STOPBITS = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_host_tx_if.slave  wr,
  output logic           datao,
  output logic           busy,
  output logic [31:0]    txcount
);

  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW      = AW + 1;
  localparam int STOPLEN = STOPBITS * DIV;
  localparam int DW      = (STOPLEN > 1) ? $clog2(STOPLEN) : 1;
  localparam logic [DW-1:0] BITLAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] STOPLAST = DW'(STOPLEN - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, nextstate;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [7:0]    shift, shiftnext;
  logic [2:0]    bitcnt, bitnext;
  logic [DW-1:0] divcnt, divnext;
  logic          push, pop, done, linenext;

  // Ready and busy come only from registered state, never from wvalid.
  assign wr.wready = (count != FULL);
  assign push      = wr.wvalid & wr.wready;
  assign busy      = (state != IDLE) | (count != '0);

  // FIFO storage; contents need no reset since count guards every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr.wdata;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Frame sequencer next-state, bit/divider counters and line value.
  always_comb begin
    nextstate = state;
    shiftnext = shift;
    bitnext   = bitcnt;
    divnext   = divcnt + 1'b1;
    pop       = 1'b0;
    done      = 1'b0;
    linenext  = 1'b1;
    case (state)
      IDLE: begin
        divnext = '0;
        if (count != '0) begin
          pop       = 1'b1;
          shiftnext = mem[rptr];
          nextstate = START;
        end
      end
      START: begin
        linenext = 1'b0;
        if (divcnt == BITLAST) begin
          divnext   = '0;
          bitnext   = '0;
          nextstate = DATA;
        end
      end
      DATA: begin
        linenext = shift[0];
        if (divcnt == BITLAST) begin
          divnext   = '0;
          shiftnext = shift >> 1;
          if (bitcnt == 3'd7) nextstate = STOP;
          else                bitnext   = bitcnt + 1'b1;
        end
      end
      STOP: begin
        if (divcnt == STOPLAST) begin
          divnext = '0;
          done    = 1'b1;
          if (count != '0) begin
            pop       = 1'b1;
            shiftnext = mem[rptr];
            nextstate = START;
          end else begin
            nextstate = IDLE;
          end
        end
      end
      default: nextstate = IDLE;
    endcase
  end

  // Sequencer state, shift register, serial line and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      bitcnt  <= '0;
      divcnt  <= '0;
      datao   <= 1'b1;
      txcount <= '0;
    end else begin
      state  <= nextstate;
      shift  <= shiftnext;
      bitcnt <= bitnext;
      divcnt <= divnext;
      datao  <= linenext;
      if (done) txcount <= txcount + 32'd1;
    end
  end

  noPushWhenFull: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == FULL)));
  noPopWhenEmpty: assert property (@(posedge clk) disable iff (rst)
    !(pop && (count == '0)));
  idleLineHigh: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE) |-> datao);

endmodule

// File: tb/tb_uart_host_tx.sv
// Bench for uart_host_tx: three instances cover DIV=1, DIV=4 and STOPBITS=2.
// Accepted bytes are queued as expected frames; a monitor decodes the active
// serial line and compares each frame against the queue head.
module tb_uart_host_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_host_tx_if if1 ();
  uart_host_tx_if if4 ();
  uart_host_tx_if if6 ();

  logic [7:0]  wdataTb  = 8'h00;
  logic        wvalidTb = 1'b0;
  int          sel      = 0;

  assign if1.wdata  = wdataTb;
  assign if4.wdata  = wdataTb;
  assign if6.wdata  = wdataTb;
  assign if1.wvalid = wvalidTb && (sel == 0);
  assign if4.wvalid = wvalidTb && (sel == 1);
  assign if6.wvalid = wvalidTb && (sel == 2);

  logic        d1, d4, d6, b1, b4, b6;
  logic [31:0] c1, c4, c6;

  uart_host_tx #(.DIV(1), .DEPTH(4), .STOPBITS(1)) dut1 (
    .clk(clk), .rst(rst), .wr(if1), .datao(d1), .busy(b1), .txcount(c1));
  uart_host_tx #(.DIV(4), .DEPTH(4), .STOPBITS(1)) dut4 (
    .clk(clk), .rst(rst), .wr(if4), .datao(d4), .busy(b4), .txcount(c4));
  uart_host_tx #(.DIV(1), .DEPTH(4), .STOPBITS(2)) dut6 (
    .clk(clk), .rst(rst), .wr(if6), .datao(d6), .busy(b6), .txcount(c6));

  logic        mline, mbusy, mready;
  logic [31:0] mcount;
  int          mdiv, mstop;

  // Route the instance under test to the shared monitor/check signals.
  always_comb begin
    mline = d1; mbusy = b1; mready = if1.wready; mcount = c1; mdiv = 1; mstop = 1;
    case (sel)
      1: begin mline = d4; mbusy = b4; mready = if4.wready; mcount = c4; mdiv = 4; mstop = 1; end
      2: begin mline = d6; mbusy = b6; mready = if6.wready; mcount = c6; mdiv = 1; mstop = 2; end
      default: ;
    endcase
  end

  int          compared   = 0;
  int          mismatched = 0;
  logic [7:0]  expQ[$];
  bit          monEnable  = 1'b0;
  bit          sawFull    = 1'b0;
  logic [31:0] cnts  [64];
  logic        busys [64];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Frame decoder: on a low sample, verify start/data/stop timing and compare the byte.
  always begin
    logic [7:0] got;
    logic [7:0] expByte;
    bit         frameOk;
    @(negedge clk);
    if (monEnable && mline === 1'b0) begin
      frameOk = 1'b1;
      got     = 8'h00;
      for (int s = 1; s < mdiv; s++) begin
        @(negedge clk);
        if (mline !== 1'b0) frameOk = 1'b0;
      end
      for (int b = 0; b < 8; b++) begin
        for (int s = 0; s < mdiv; s++) begin
          @(negedge clk);
          if (s == 0) got[b] = mline;
          else if (mline !== got[b]) frameOk = 1'b0;
        end
      end
      for (int s = 0; s < mstop * mdiv; s++) begin
        @(negedge clk);
        if (mline !== 1'b1) frameOk = 1'b0;
      end
      checkOutput("frameExpected", expQ.size() != 0, 1'b1);
      checkOutput("frameTiming", frameOk, 1'b1);
      if (expQ.size() != 0) begin
        expByte = expQ.pop_front();
        checkOutput("frameByte", got, expByte);
      end
    end
  end

  task automatic resetAll();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit track);
    int tries;
    tries    = 0;
    wdataTb  = b;
    wvalidTb = 1'b1;
    while (!mready && tries < 100) begin
      sawFull = 1'b1;
      @(negedge clk);
      tries++;
    end
    if (tries >= 100) checkOutput("wreadyTimeout", tries, 0);
    @(posedge clk);
    if (track) expQ.push_back(b);
    @(negedge clk);
  endtask

  task automatic captureLine(input int n, output logic [63:0] bits, output int lat);
    bits = '0;
    lat  = 0;
    while (mline !== 1'b0 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("startSeen", mline === 1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      bits     = {bits[62:0], mline};
      cnts[i]  = mcount;
      busys[i] = mbusy;
    end
  endtask

  task automatic waitDrain();
    int tries;
    tries = 0;
    while ((expQ.size() != 0 || mbusy) && tries < 2000) begin
      @(negedge clk);
      tries++;
    end
    checkOutput("drainInTime", tries < 2000, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] bits;
    logic [63:0] expBits;
    logic [9:0]  frame10;
    int          lat;

    // Test 1: reset state, latency and a single 0xA5 frame.
    sel = 0;
    resetAll();
    checkOutput("t1RstLine", mline, 1'b1);
    checkOutput("t1RstBusy", mbusy, 1'b0);
    checkOutput("t1RstCount", mcount, 32'd0);
    checkOutput("t1RstWready", mready, 1'b1);
    monEnable = 1'b1;
    applyStimulus(8'hA5, 1'b1);
    wvalidTb = 1'b0;
    captureLine(10, bits, lat);
    checkOutput("t1Latency", lat, 2);
    checkOutput("t1Frame", bits, 64'b0101001011);
    @(negedge clk);
    checkOutput("t1Count", mcount, 32'd1);
    checkOutput("t1BusyAfter", mbusy, 1'b0);
    checkOutput("t1LineAfter", mline, 1'b1);
    waitDrain();

    // Test 2: 0x00 then 0xFF back to back, no idle bit between frames.
    resetAll();
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    wvalidTb = 1'b0;
    captureLine(20, bits, lat);
    checkOutput("t2Stream", bits, 64'b0_00000000_1_0_11111111_1);
    waitDrain();
    checkOutput("t2Count", mcount, 32'd2);

    // Test 3: continuous writes of 0x01..0x08 fill the 4-deep FIFO.
    resetAll();
    sawFull = 1'b0;
    for (int b = 1; b <= 8; b++) applyStimulus(8'(b), 1'b1);
    wvalidTb = 1'b0;
    checkOutput("t3WreadyDropped", sawFull, 1'b1);
    waitDrain();
    checkOutput("t3Count", mcount, 32'd8);
    checkOutput("t3Wready", mready, 1'b1);

    // Test 4: DIV=4, 0x3C, each bit held four cycles.
    sel = 1;
    resetAll();
    applyStimulus(8'h3C, 1'b1);
    wvalidTb = 1'b0;
    captureLine(40, bits, lat);
    frame10 = 10'b0001111001;
    expBits = '0;
    for (int i = 0; i < 10; i++)
      for (int s = 0; s < 4; s++) expBits = {expBits[62:0], frame10[9 - i]};
    checkOutput("t4Frame", bits, expBits);
    checkOutput("t4BusyDuring", busys[8], 1'b1);
    @(negedge clk);
    checkOutput("t4BusyAfter", mbusy, 1'b0);
    checkOutput("t4Count", mcount, 32'd1);
    waitDrain();

    // Test 5: reset during data bit 3 of 0x55 with two bytes queued.
    sel = 0;
    resetAll();
    monEnable = 1'b0;
    applyStimulus(8'h55, 1'b0);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    wvalidTb = 1'b0;
    captureLine(5, bits, lat);
    checkOutput("t5BusyBefore", mbusy, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("t5RstLine", mline, 1'b1);
    checkOutput("t5RstCount", mcount, 32'd0);
    checkOutput("t5RstWready", mready, 1'b1);
    checkOutput("t5RstBusy", mbusy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5IdleLine", mline, 1'b1);
    monEnable = 1'b1;
    applyStimulus(8'h81, 1'b1);
    wvalidTb = 1'b0;
    captureLine(10, bits, lat);
    checkOutput("t5Frame", bits, 64'b0100000011);
    waitDrain();
    checkOutput("t5Count", mcount, 32'd1);

    // Test 6: STOPBITS=2, 0x0F and 0xF0 back to back.
    sel = 2;
    resetAll();
    applyStimulus(8'h0F, 1'b1);
    applyStimulus(8'hF0, 1'b1);
    wvalidTb = 1'b0;
    captureLine(22, bits, lat);
    checkOutput("t6Stream", bits, 64'b0_11110000_11_0_00001111_11);
    checkOutput("t6CountStop1", cnts[9], 32'd0);
    checkOutput("t6CountStop2", cnts[10], 32'd1);
    checkOutput("t6CountF2Stop1", cnts[20], 32'd1);
    checkOutput("t6CountF2Stop2", cnts[21], 32'd2);
    waitDrain();
    checkOutput("t6Count", mcount, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute time bound in case a wait above never resolves.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
